// File: rtl/hazard_ctrl_mc.sv
// Hazard controller beside ID: RAW stalls against EXE/MEM, redirect flush, multi-cycle freeze.
// Optional build macro HAZARD_FORWARD_EN adds fwd_a/fwd_b and relaxes stalls to load-use/branch.
module hazard_ctrl_mc #(
    parameter int REG_W   = 5,
    parameter int MC_LAT  = 4,
    parameter int CNT_W   = 16,
    parameter int R0_SKIP = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic             uses_rt_id,
    input  logic             branch_id,
    input  logic [REG_W-1:0] wr_num_exe,
    input  logic             reg_write_exe,
    input  logic             mem_read_exe,
    input  logic [REG_W-1:0] wr_num_mem,
    input  logic             reg_write_mem,
    input  logic             mem_read_mem,
    input  logic [1:0]       npc_sel,
    input  logic             zero,
    input  logic             mc_start_id,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_exe_flush,
    output logic             mc_busy,
    output logic [CNT_W-1:0] stall_cnt
`ifdef HAZARD_FORWARD_EN
    ,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
`endif
);

    // state   | meaning
    // RUN     | normal operation; multi-cycle op may issue
    // MC_WAIT | multi-cycle op occupies EXE; front end frozen
    typedef enum logic {RUN, MC_WAIT} state_t;

    localparam int CW = $clog2(MC_LAT + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           busy_q;

    logic skip_exe, skip_mem;
    logic rs_exe, rt_exe, rs_mem, rt_mem;
    logic raw_exe, raw_mem;
    logic stall, redirect;

    assign skip_exe = (R0_SKIP != 0) && (wr_num_exe == '0);
    assign skip_mem = (R0_SKIP != 0) && (wr_num_mem == '0);

    assign rs_exe = reg_write_exe && !skip_exe && (rs_id == wr_num_exe);
    assign rt_exe = reg_write_exe && !skip_exe && uses_rt_id && (rt_id == wr_num_exe);
    assign rs_mem = reg_write_mem && !skip_mem && (rs_id == wr_num_mem);
    assign rt_mem = reg_write_mem && !skip_mem && uses_rt_id && (rt_id == wr_num_mem);

    assign raw_exe = rs_exe || rt_exe;
    assign raw_mem = rs_mem || rt_mem;

`ifdef HAZARD_FORWARD_EN
    // Forwarding covers ALU results; only loads and ID-stage branch compares must wait.
    assign stall = (mem_read_exe && raw_exe)
                || (branch_id && (raw_exe || (mem_read_mem && raw_mem)));
`else
    assign stall = raw_exe || raw_mem;
`endif

    assign redirect = ((npc_sel == 2'd1) && zero) || (npc_sel == 2'd2) || (npc_sel == 2'd3);

    always_comb begin
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_exe_flush = 1'b0;
        if (reset) begin
            if (state == MC_WAIT || stall) begin
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_exe_flush = 1'b1;
            end else if (redirect) begin
                if_id_write  = 1'b0;
                if_id_flush  = 1'b1;
            end
        end
    end

`ifdef HAZARD_FORWARD_EN
    always_comb begin
        fwd_a = 2'd0;
        fwd_b = 2'd0;
        if (reset) begin
            if (rs_exe)      fwd_a = 2'd1;
            else if (rs_mem) fwd_a = 2'd2;
            if (rt_exe)      fwd_b = 2'd1;
            else if (rt_mem) fwd_b = 2'd2;
        end
    end
`endif

    assign mc_busy = busy_q && reset;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= RUN;
            cnt       <= '0;
            busy_q    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (!pc_write && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            case (state)
                RUN: begin
                    // A stalled op issues later, once its operands are ready.
                    if (mc_start_id && !stall && (MC_LAT > 1)) begin
                        state  <= MC_WAIT;
                        busy_q <= 1'b1;
                        cnt    <= CW'(MC_LAT - 1);
                    end
                end
                MC_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        state  <= RUN;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= RUN;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
